// File: rtl/router_pkg.sv
// Shared definitions for the router packet source.
// Header field widths, the illegal address code and the FSM states.
package router_pkg;

    localparam int HDR_ADDR_W = 2;
    localparam int HDR_LEN_W  = 6;
    localparam int HDR_W      = HDR_ADDR_W + HDR_LEN_W;

    localparam logic [HDR_ADDR_W-1:0] ADDR_INVALID = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_HDR,
        S_PLD,
        S_PAR,
        S_GAP
    } tx_state_t;

    function automatic logic [HDR_W-1:0] mk_hdr(
        input logic [HDR_LEN_W-1:0]  len,
        input logic [HDR_ADDR_W-1:0] addr
    );
        return {len, addr};
    endfunction

endpackage

// File: rtl/router_pkt_tx_if.sv
// Request, payload and router-side signals of the packet source.
// slave is the packet source itself, master is whoever drives it.
interface router_pkt_tx_if;
    import router_pkg::*;

    logic                  req_valid;
    logic                  req_ready;
    logic [HDR_ADDR_W-1:0] req_addr;
    logic [HDR_LEN_W-1:0]  req_len;

    logic [7:0]            pl_data;
    logic                  pl_valid;
    logic                  pl_ready;

    logic                  busy;
    logic [7:0]            data_out;
    logic                  pkt_valid;
    logic                  tx_done;
    logic                  req_err;

    modport slave (
        input  req_valid,
        input  req_addr,
        input  req_len,
        input  pl_data,
        input  pl_valid,
        input  busy,
        output req_ready,
        output pl_ready,
        output data_out,
        output pkt_valid,
        output tx_done,
        output req_err
    );

    modport master (
        output req_valid,
        output req_addr,
        output req_len,
        output pl_data,
        output pl_valid,
        output busy,
        input  req_ready,
        input  pl_ready,
        input  data_out,
        input  pkt_valid,
        input  tx_done,
        input  req_err
    );

endinterface

// File: rtl/router_tx_buf.sv
// Single-clock payload buffer with independent write/read pointers.
// clr rewinds both pointers; stored bytes are simply overwritten later.
module router_tx_buf #(
    parameter int DEPTH = 63
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       rd_en,
    output logic [7:0] rd_data
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Combinational read so the next byte is ready on the transfer edge.
    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/router_pkt_tx.sv
// Packet source for the 1x3 router: buffers a payload, then sends
// header, payload and parity back to back, stalling on busy.
module router_pkt_tx
    import router_pkg::*;
#(
    parameter int MAX_LEN = 63,
    parameter int IFG     = 3
) (
    input logic             clock,
    input logic             resetn,
    router_pkt_tx_if.slave  io
);

    localparam int GW = (IFG > 0) ? $clog2(IFG + 1) : 1;
    localparam logic [HDR_LEN_W-1:0] LEN_MAX = HDR_LEN_W'(MAX_LEN);

    tx_state_t             state;
    logic [HDR_ADDR_W-1:0] addr_q;
    logic [HDR_LEN_W-1:0]  len_q;
    logic [7:0]            parity;
    logic [HDR_LEN_W-1:0]  wr_cnt;
    logic [HDR_LEN_W-1:0]  rd_cnt;
    logic [GW-1:0]         gap_cnt;

    logic       req_fire;
    logic       req_bad;
    logic       buf_clr;
    logic       buf_wr;
    logic       buf_rd;
    logic       last_wr;
    logic       last_rd;
    logic [7:0] buf_data;

    assign req_fire = (state == S_IDLE) && io.req_valid && io.req_ready;
    assign req_bad  = (io.req_addr == ADDR_INVALID)
                   || (io.req_len == '0)
                   || (io.req_len > LEN_MAX);

    assign buf_clr = req_fire && !req_bad;
    assign buf_wr  = (state == S_LOAD) && io.pl_valid && io.pl_ready;
    assign last_wr = (wr_cnt == len_q - HDR_LEN_W'(1));
    assign last_rd = (rd_cnt == len_q);

    // Advance the read pointer each time a payload byte is put on the bus.
    always_comb begin
        buf_rd = 1'b0;
        unique case (1'b1)
            (state == S_HDR): buf_rd = !io.busy;
            (state == S_PLD): buf_rd = !io.busy && !last_rd;
            default:          buf_rd = 1'b0;
        endcase
    end

    router_tx_buf #(
        .DEPTH (MAX_LEN)
    ) u_buf (
        .clk     (clock),
        .rst_n   (resetn),
        .clr     (buf_clr),
        .wr_en   (buf_wr),
        .wr_data (io.pl_data),
        .rd_en   (buf_rd),
        .rd_data (buf_data)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state        <= S_IDLE;
            addr_q       <= '0;
            len_q        <= '0;
            parity       <= '0;
            wr_cnt       <= '0;
            rd_cnt       <= '0;
            gap_cnt      <= '0;
            io.req_ready <= 1'b0;
            io.pl_ready  <= 1'b0;
            io.data_out  <= '0;
            io.pkt_valid <= 1'b0;
            io.tx_done   <= 1'b0;
            io.req_err   <= 1'b0;
        end else begin
            io.tx_done <= 1'b0;
            io.req_err <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    io.req_ready <= 1'b1;
                    if (req_fire) begin
                        if (req_bad) begin
                            io.req_err <= 1'b1;
                        end else begin
                            addr_q       <= io.req_addr;
                            len_q        <= io.req_len;
                            parity       <= mk_hdr(io.req_len, io.req_addr);
                            wr_cnt       <= '0;
                            io.req_ready <= 1'b0;
                            io.pl_ready  <= 1'b1;
                            state        <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    if (buf_wr) begin
                        parity <= parity ^ io.pl_data;
                        wr_cnt <= wr_cnt + HDR_LEN_W'(1);
                        if (last_wr) begin
                            io.pl_ready  <= 1'b0;
                            io.data_out  <= mk_hdr(len_q, addr_q);
                            io.pkt_valid <= 1'b1;
                            state        <= S_HDR;
                        end
                    end
                end
                S_HDR: begin
                    if (!io.busy) begin
                        io.data_out <= buf_data;
                        rd_cnt      <= HDR_LEN_W'(1);
                        state       <= S_PLD;
                    end
                end
                S_PLD: begin
                    if (!io.busy) begin
                        if (last_rd) begin
                            io.data_out  <= parity;
                            io.pkt_valid <= 1'b0;
                            state        <= S_PAR;
                        end else begin
                            io.data_out <= buf_data;
                            rd_cnt      <= rd_cnt + HDR_LEN_W'(1);
                        end
                    end
                end
                S_PAR: begin
                    if (!io.busy) begin
                        io.data_out <= '0;
                        io.tx_done  <= 1'b1;
                        gap_cnt     <= '0;
                        state       <= S_GAP;
                    end
                end
                S_GAP: begin
                    // One tx_done cycle followed by IFG quiet cycles.
                    if (gap_cnt == GW'(IFG)) begin
                        io.req_ready <= 1'b1;
                        state        <= S_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Randomized bench for router_pkt_tx: a packet-level model predicts the
// byte stream, parity, tx_done timing and inter-frame gap.
module tb_router_pkt_tx;
    import router_pkg::*;

    localparam int MAX_LEN = 63;
    localparam int IFG     = 3;
    localparam int BOUND   = 4000;

    logic clock  = 1'b0;
    logic resetn = 1'b0;

    router_pkt_tx_if io ();

    router_pkt_tx #(
        .MAX_LEN (MAX_LEN),
        .IFG     (IFG)
    ) dut (
        .clock  (clock),
        .resetn (resetn),
        .io     (io)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] pl [$];

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s got=%0h want=%0h t=%0t", tag, got, want, $time);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!io.req_ready && n < BOUND) begin
            @(negedge clock);
            n++;
        end
        if (!io.req_ready) chk("ready_timeout", 0, 1);
    endtask

    task automatic fill_rand(input int len);
        pl.delete();
        for (int i = 0; i < len; i++) pl.push_back(8'($urandom));
    endtask

    // mode: 0 no busy, 1 random busy, 2 busy 2 cycles on header and
    // first byte, 3 busy 3 cycles on the parity byte
    task automatic run_pkt(input int addr, input int mode,
                           input int plv_pct, input int abort_at);
        logic [7:0] ex_q [$];
        logic [7:0] par;
        logic [7:0] held_d;
        int  len = pl.size();
        int  ntx = 0, sent = 0, hold_cnt = 0, gap_cyc = 0;
        bit  have_held = 0, plv_prev = 0, plr_prev = 0;
        bit  seen_hdr = 0, done = 0;

        par = 8'((len << 2) | addr);
        ex_q.push_back(par);
        foreach (pl[i]) begin
            ex_q.push_back(pl[i]);
            par = par ^ pl[i];
        end
        ex_q.push_back(par);

        wait_ready();
        io.req_valid = 1'b1;
        io.req_addr  = 2'(addr);
        io.req_len   = 6'(len);
        @(negedge clock);
        io.req_valid = 1'b0;

        for (int cyc = 0; cyc < BOUND && !done; cyc++) begin
            if (plv_prev && plr_prev) begin
                sent++;
                if (sent == len) chk("pl_drop", io.pl_ready, 0);
            end
            plr_prev = io.pl_ready;
            if (sent < len) begin
                io.pl_valid = ($urandom_range(99) < plv_pct);
                io.pl_data  = pl[sent];
            end else begin
                io.pl_valid = 1'b1;
                io.pl_data  = 8'hA5;
            end
            plv_prev = io.pl_valid;

            if (abort_at > 0 && ntx == abort_at) begin
                resetn = 1'b0;
                #1;
                chk("rst_pv", io.pkt_valid, 0);
                chk("rst_do", io.data_out, 0);
                chk("rst_rr", io.req_ready, 0);
                io.busy     = 1'b0;
                io.pl_valid = 1'b0;
                repeat (2) @(negedge clock);
                resetn = 1'b1;
                @(negedge clock);
                chk("rst_rr1", io.req_ready, 1);
                return;
            end

            unique case (mode)
                1: io.busy = ($urandom_range(99) < 30);
                2: io.busy = io.pkt_valid && ntx <= 1 && hold_cnt < 2;
                3: io.busy = (ntx == len + 1) && hold_cnt < 3;
                default: io.busy = 1'b0;
            endcase
            if (io.busy) hold_cnt++;

            if (ntx <= len) begin
                if (io.pkt_valid) begin
                    if (!seen_hdr) begin
                        chk("pl_count", sent, len);
                        seen_hdr = 1;
                    end
                    if (have_held) chk("hold", io.data_out, held_d);
                    if (!io.busy) begin
                        chk($sformatf("byte%0d", ntx), io.data_out, ex_q[ntx]);
                        ntx++;
                        have_held = 0;
                        hold_cnt  = 0;
                    end else begin
                        held_d    = io.data_out;
                        have_held = 1;
                    end
                end else if (ntx > 0) begin
                    chk("bubble", io.pkt_valid, 1);
                end
            end else if (ntx == len + 1) begin
                chk("par_pv", io.pkt_valid, 0);
                if (have_held) chk("par_hold", io.data_out, held_d);
                if (!io.busy) begin
                    chk("parity", io.data_out, ex_q[len + 1]);
                    ntx++;
                    have_held = 0;
                end else begin
                    held_d    = io.data_out;
                    have_held = 1;
                end
            end else begin
                gap_cyc++;
                if (gap_cyc <= 2) chk("tx_done", io.tx_done, (gap_cyc == 1));
                if (io.req_ready) begin
                    chk("ifg", gap_cyc - 1, IFG + 1);
                    done = 1;
                end else begin
                    chk("gap_pv", io.pkt_valid, 0);
                end
            end
            if (!done) @(negedge clock);
        end
        if (!done) chk("pkt_timeout", 0, 1);
        io.pl_valid = 1'b0;
        io.busy     = 1'b0;
    endtask

    task automatic bad_req(input int addr, input int len);
        wait_ready();
        io.req_valid = 1'b1;
        io.req_addr  = 2'(addr);
        io.req_len   = 6'(len);
        io.pl_valid  = 1'b1;
        @(negedge clock);
        io.req_valid = 1'b0;
        chk("err_pulse", io.req_err, 1);
        for (int i = 0; i < 3; i++) begin
            chk("err_plr", io.pl_ready, 0);
            chk("err_pv", io.pkt_valid, 0);
            @(negedge clock);
            chk("err_low", io.req_err, 0);
        end
        io.pl_valid = 1'b0;
    endtask

    initial begin
        io.req_valid = 1'b0;
        io.req_addr  = '0;
        io.req_len   = '0;
        io.pl_data   = '0;
        io.pl_valid  = 1'b0;
        io.busy      = 1'b0;

        repeat (2) @(negedge clock);
        chk("rst_req_ready", io.req_ready, 0);
        chk("rst_data_out", io.data_out, 0);
        chk("rst_pkt_valid", io.pkt_valid, 0);
        chk("rst_pl_ready", io.pl_ready, 0);
        chk("rst_tx_done", io.tx_done, 0);
        chk("rst_req_err", io.req_err, 0);
        resetn = 1'b1;
        @(negedge clock);
        chk("rel_req_ready", io.req_ready, 1);

        pl = '{8'h11, 8'h22, 8'h33};
        run_pkt(1, 0, 100, -1);
        pl = '{8'h11, 8'h22, 8'h33};
        run_pkt(1, 2, 100, -1);

        bad_req(3, 4);
        bad_req(1, 0);
        fill_rand(5);
        run_pkt(0, 1, 80, -1);

        fill_rand(63);
        run_pkt(2, 0, 50, -1);

        fill_rand(10);
        run_pkt(1, 1, 100, 4);
        fill_rand(7);
        run_pkt(2, 1, 70, -1);

        fill_rand(4);
        run_pkt(0, 3, 100, -1);
        fill_rand(6);
        run_pkt(1, 3, 100, -1);

        for (int k = 0; k < 20; k++) begin
            fill_rand($urandom_range(1, MAX_LEN));
            run_pkt($urandom_range(0, 2), 1, $urandom_range(30, 100), -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
